// File: rtl/mont_final_sub_pkg.sv
// Shared definitions for the Montgomery final conditional-subtract stage:
// state encoding, default widths and slice-count helpers.
package mont_pkg;

    localparam int NBITS_DEF = 256;
    localparam int WBITS_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nwords(input int nbits, input int wbits);
        return nbits / wbits;
    endfunction

    // A single-slice configuration still needs a one-bit index register.
    function automatic int idx_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/mont_final_sub_if.sv
// Handshake bundle between the Montgomery sum adder, the final-subtract
// stage and its consumer.
interface mont_final_sub_if
    import mont_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] t;
    logic             t_cout;
    logic [NBITS-1:0] m;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] y;
    logic             subtracted;

    modport master (
        output in_valid, t, t_cout, m, out_ready,
        input  in_ready, out_valid, y, subtracted
    );

    modport slave (
        input  in_valid, t, t_cout, m, out_ready,
        output in_ready, out_valid, y, subtracted
    );
endinterface

// File: rtl/mont_final_sub_add_3.sv
// Three-input adder (two operands plus carry-in) with carry-out; used here
// as the per-slice subtractor by feeding it an inverted operand.
module add_3 #(
    parameter int NBITS = 64
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             c,
    output logic [NBITS-1:0] y,
    output logic             cout
);
    assign {cout, y} = {1'b0, a} + {1'b0, b} + (NBITS+1)'(c);
endmodule

// File: rtl/mont_final_sub.sv
// Final conditional subtract of a Montgomery product: y = V - m if V >= m,
// otherwise t, with V = t_cout*2^NBITS + t, computed WBITS bits per cycle.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SUB   | subtracting one WBITS slice per cycle, LSW first
// DONE  | result held on y/subtracted until out_ready
module mont_final_sub
    import mont_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int WBITS = WBITS_DEF
) (
    input logic             clk,
    input logic             rst_n,
    mont_final_sub_if.slave bus
);
    localparam int NWORDS = nwords(NBITS, WBITS);
    localparam int IW     = idx_width(NWORDS);

    if (NBITS % WBITS != 0) begin : g_bad_width
        $error("mont_final_sub: NBITS must be an integer multiple of WBITS");
    end

    state_t           state;
    logic [NBITS-1:0] t_q;
    logic [NBITS-1:0] t_sh;
    logic [NBITS-1:0] m_sh;
    logic [NBITS-1:0] diff_q;
    logic [NBITS-1:0] diff_next;
    logic [NBITS-1:0] y_q;
    logic             tc_q;
    logic             carry_q;
    logic             sub_q;
    logic             out_valid_q;
    logic [IW-1:0]    idx_q;
    logic [WBITS-1:0] slice_sum;
    logic             slice_cout;
    logic             last;
    logic             sel;

    // t - m as t + ~m + 1; the carry register starts at 1 and ripples between slices.
    add_3 #(.NBITS(WBITS)) u_slice (
        .a    (t_sh[WBITS-1:0]),
        .b    (~m_sh[WBITS-1:0]),
        .c    (carry_q),
        .y    (slice_sum),
        .cout (slice_cout)
    );

    // Difference slices enter at the top so the LSW lands at bit 0 after NWORDS shifts.
    assign diff_next = (diff_q >> WBITS) | (NBITS'(slice_sum) << (NBITS - WBITS));
    assign last      = (idx_q == IW'(NWORDS - 1));
    assign sel       = tc_q | slice_cout;

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.y          = y_q;
    assign bus.subtracted = sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            t_q         <= '0;
            t_sh        <= '0;
            m_sh        <= '0;
            diff_q      <= '0;
            y_q         <= '0;
            tc_q        <= 1'b0;
            carry_q     <= 1'b1;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        t_q     <= bus.t;
                        t_sh    <= bus.t;
                        m_sh    <= bus.m;
                        tc_q    <= bus.t_cout;
                        diff_q  <= '0;
                        carry_q <= 1'b1;
                        idx_q   <= '0;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    t_sh    <= t_sh >> WBITS;
                    m_sh    <= m_sh >> WBITS;
                    diff_q  <= diff_next;
                    carry_q <= slice_cout;
                    if (last) begin
                        y_q         <= sel ? diff_next : t_q;
                        sub_q       <= sel;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        state       <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mont_final_sub.md
Name: mont_final_sub

Overview:
- Sequential conditional-subtract stage directly downstream of the Montgomery sum adder (`add`).
- Consumes the adder's sum and carry-out, both already < 2M, and produces the fully reduced result in [0, M).
- Word-serial: the NBITS-wide subtraction is split into WBITS-wide slices to bound the carry chain. Costs NWORDS cycles per operand.
- Valid/ready handshakes on both sides; holds one operation at a time.

Parameters:
- NBITS, 256, operand/modulus width; must be an integer multiple of WBITS (elaboration error otherwise)
- WBITS, 64, slice width processed per cycle
- NWORDS, NBITS/WBITS, derived localparam, not overridable

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  stage can accept; high only in IDLE
- t  input  NBITS  sum from upstream adder (y of `add`)
- t_cout  input  1  carry-out from upstream adder (cout of `add`)
- m  input  NBITS  modulus, odd, nonzero
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- y  output  NBITS  reduced result
- subtracted  output  1  1 when y = t - m was selected

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, y=0, subtracted=0, slice index=0, carry=1. in_ready=1 once reset is released.
- in_ready is combinational from state (IDLE). out_valid is registered.
- Value represented: V = t_cout*2^NBITS + t. Precondition V < 2m is not checked.

FSM states: IDLE, SUB, DONE.
- IDLE:
  - On in_valid && in_ready, latch t, m, t_cout.
  - Clear the diff register; set carry=1 (no borrow); set idx=0; go to SUB.
  - in_valid while not in IDLE is ignored; upstream must hold its data.
- SUB, one slice per cycle, LSW first:
  - d[idx] = t[idx] + ~m[idx] + carry, computed as a WBITS add with carry-in.
  - carry <= slice carry-out; idx increments.
  - Stays exactly NWORDS cycles.
  - On the last SUB edge, form the final carry c_f and sel = t_cout | c_f. Register y = sel ? d : t_latched and subtracted = sel. Set out_valid=1 and go to DONE.
- Latency: out_valid rises NWORDS clock edges after the accepting edge.
- DONE:
  - y, subtracted and out_valid are held stable while out_ready=0.
  - On out_ready, next state is IDLE and out_valid=0. y keeps its value; it is not cleared.
  - No same-cycle accept of new input in DONE. Throughput is one operation per NWORDS+2 cycles.
- Arithmetic:
  - When t_cout=1, y = (t - m) mod 2^NBITS; the final borrow is ignored.
  - t == m gives y=0, subtracted=1.
  - The latched t is kept unmodified for the bypass select. Index slices by idx or rotate registers; either is acceptable.
- Reset mid-operation: asynchronous return to reset values. The in-flight operation is discarded and nothing is emitted.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package `mont_pkg`:
  - state encoding localparams IDLE/SUB/DONE
  - default NBITS/WBITS
  - helper for NWORDS and idx width, $clog2(NWORDS) with minimum 1
- Sub-module: reuse the existing `add_3` with NBITS=WBITS as the slice subtractor: a=t slice, b=~m slice, c=carry, cout=next carry.
- No other sub-modules.

Test Plan (NBITS=16, WBITS=4, NWORDS=4):
- t=0x1234, m=0x1000, t_cout=0 -> y=0x0234, subtracted=1, out_valid exactly 4 edges after accept.
- t=0x0FFF, m=0x1000, t_cout=0 -> y=0x0FFF, subtracted=0 (cross-slice borrow path).
- t=0xABCD, m=0xABCD -> y=0x0000, subtracted=1.
- t_cout=1, t=0x0005, m=0xFFF1 -> y=0x0014, subtracted=1.
- Hold out_ready=0 for 5 cycles after result 0x0234 while toggling in_valid with new data -> y/out_valid stable, in_ready=0, second operand accepted only after the out_ready handshake, and its result is correct.
- Assert rst_n=0 during the 2nd SUB cycle -> out_valid=0, y=0, subtracted=0 immediately. After release, in_ready=1 and the next operand t=0x2000, m=0x1001 gives y=0x0FFF.
